// File: rtl/seg_led_capture_if.sv
// Scanned display bus seen by seg_led_capture: digit-select/segment inputs and
// the reconstructed value/point/sign/enable word with its status pulses.
interface seg_led_capture_if;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_led;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        en;
    logic        valid;
    logic        err;

    modport master (
        output seg_sel, seg_led,
        input  data, point, sign, en, valid, err
    );

    modport slave (
        input  seg_sel, seg_led,
        output data, point, sign, en, valid, err
    );
endinterface

// File: rtl/seg_led_capture.sv
// Captures a scanned six-digit seven-segment display and rebuilds its value word.
// Optional macro SEG_CAP_TIMEOUT_EN: drop en after TIMEOUT_CYC cycles of all digits off.
module seg_led_capture #(
    parameter int unsigned STABLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 500_000
) (
    input logic               clk,
    input logic               rst,
    seg_led_capture_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_CONV  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] G_BLANK = 4'd10;
    localparam logic [3:0] G_MINUS = 4'd11;
    localparam logic [3:0] G_BAD   = 4'd15;

    localparam logic [7:0] STB_LAST = 8'(STABLE_CYC - 1);
    localparam logic [7:0] STB_PRE  = 8'(STABLE_CYC - 2);

    logic [5:0]      sel_s1_q, sel_s2_q;
    logic [7:0]      led_s1_q, led_s2_q;
    logic [13:0]     prev_q;
    logic [7:0]      stb_cnt_q, stb_cnt_d;
    logic            same, sel_onehot, latch_en;
    logic [2:0]      slot_idx;
    logic [3:0]      glyph;

    logic [5:0][3:0] code_q, code_d;
    logic [5:0]      dp_q, dp_d;
    logic [5:0]      mask_q, mask_d;
    logic [5:0][3:0] snap_code_q, snap_code_d;
    logic [5:0]      snap_dp_q, snap_dp_d;

    logic [1:0]      state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [19:0]     acc_q, acc_d, acc_next;
    logic [3:0]      cur_code, cur_digit;
    logic            accept, frame_bad, frame_minus;
    logic [2:0]      minus_cnt;
    logic            tmo_fire;

    logic [19:0]     data_q, data_d;
    logic [5:0]      point_q, point_d;
    logic            sign_q, sign_d;
    logic            en_q, en_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    function automatic logic [3:0] decode_glyph(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_glyph = 4'd0;
            7'h79:   decode_glyph = 4'd1;
            7'h24:   decode_glyph = 4'd2;
            7'h30:   decode_glyph = 4'd3;
            7'h19:   decode_glyph = 4'd4;
            7'h12:   decode_glyph = 4'd5;
            7'h02:   decode_glyph = 4'd6;
            7'h78:   decode_glyph = 4'd7;
            7'h00:   decode_glyph = 4'd8;
            7'h10:   decode_glyph = 4'd9;
            7'h7F:   decode_glyph = G_BLANK;
            7'h3F:   decode_glyph = G_MINUS;
            default: decode_glyph = G_BAD;
        endcase
    endfunction

    // Stability filter: counter saturates at STB_LAST, so a slot latches once per change.
    assign same       = ({sel_s2_q, led_s2_q} == prev_q);
    assign sel_onehot = $onehot(~sel_s2_q);
    assign latch_en   = same && (stb_cnt_q == STB_PRE) && sel_onehot;
    assign glyph      = decode_glyph(led_s2_q[6:0]);

    always_comb begin
        stb_cnt_d = stb_cnt_q;
        if (!same)
            stb_cnt_d = '0;
        else if (stb_cnt_q != STB_LAST)
            stb_cnt_d = stb_cnt_q + 8'd1;
    end

    always_comb begin
        slot_idx = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (!sel_s2_q[i])
                slot_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_s1_q  <= '0;
            sel_s2_q  <= '0;
            led_s1_q  <= '0;
            led_s2_q  <= '0;
            prev_q    <= '0;
            stb_cnt_q <= '0;
        end else begin
            sel_s1_q  <= bus.seg_sel;
            sel_s2_q  <= sel_s1_q;
            led_s1_q  <= bus.seg_led;
            led_s2_q  <= led_s1_q;
            prev_q    <= {sel_s2_q, led_s2_q};
            stb_cnt_q <= stb_cnt_d;
        end
    end

`ifdef SEG_CAP_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_PRE  = TMO_W'(TIMEOUT_CYC - 2);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             all_off;

    assign all_off  = (sel_s2_q == 6'h3F);
    assign tmo_fire = all_off && (tmo_cnt_q == TMO_PRE);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (!all_off)
            tmo_cnt_d = '0;
        else if (tmo_cnt_q != TMO_LAST)
            tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt_q <= '0;
        else
            tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
    assign tmo_fire           = 1'b0;
`endif

    always_comb begin
        minus_cnt = '0;
        frame_bad = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (snap_code_q[i] == G_MINUS)
                minus_cnt = minus_cnt + 3'd1;
            if (snap_code_q[i] == G_BAD)
                frame_bad = 1'b1;
        end
        if (minus_cnt > 3'd1)
            frame_bad = 1'b1;
        frame_minus = (minus_cnt != 3'd0);
    end

    assign cur_code  = snap_code_q[idx_q];
    assign cur_digit = (cur_code < 4'd10) ? cur_code : 4'd0;
    assign acc_next  = acc_q * 20'd10 + {16'd0, cur_digit};
    assign accept    = (state_q == S_IDLE) && (mask_q == 6'h3F);

    always_comb begin
        code_d      = code_q;
        dp_d        = dp_q;
        mask_d      = mask_q;
        snap_code_d = snap_code_q;
        snap_dp_d   = snap_dp_q;
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        data_d      = data_q;
        point_d     = point_q;
        sign_d      = sign_q;
        en_d        = en_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        // Snapshot before the same-cycle latch so a new slot starts the next frame.
        if (accept) begin
            snap_code_d = code_q;
            snap_dp_d   = dp_q;
            mask_d      = '0;
        end
        if (latch_en) begin
            code_d[slot_idx] = glyph;
            dp_d[slot_idx]   = ~led_s2_q[7];
            mask_d[slot_idx] = 1'b1;
        end
        if (tmo_fire) begin
            mask_d = '0;
            en_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = S_CHECK;
            end
            S_CHECK: begin
                if (frame_bad) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = 3'd5;
                    acc_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                acc_d = acc_next;
                if (idx_q == 3'd0) begin
                    // Outputs load on the edge entering DONE so valid is high during DONE.
                    data_d  = acc_next;
                    point_d = snap_dp_q;
                    sign_d  = frame_minus;
                    en_d    = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q      <= '0;
            dp_q        <= '0;
            mask_q      <= '0;
            snap_code_q <= '0;
            snap_dp_q   <= '0;
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            data_q      <= '0;
            point_q     <= '0;
            sign_q      <= 1'b0;
            en_q        <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            code_q      <= code_d;
            dp_q        <= dp_d;
            mask_q      <= mask_d;
            snap_code_q <= snap_code_d;
            snap_dp_q   <= snap_dp_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            point_q     <= point_d;
            sign_q      <= sign_d;
            en_q        <= en_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.data  = data_q;
    assign bus.point = point_q;
    assign bus.sign  = sign_q;
    assign bus.en    = en_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_seg_led_capture.sv
// Directed bench for seg_led_capture: table of scanned frames plus latency,
// timeout and reset-during-conversion sequences.
module tb_seg_led_capture;

    localparam int HOLD = 24;
    localparam int NV   = 10;
`ifdef SEG_CAP_TIMEOUT_EN
    localparam logic EXP_EN_TMO = 1'b0;
`else
    localparam logic EXP_EN_TMO = 1'b1;
`endif

    typedef struct packed {
        logic [47:0] pat;
        logic        glitch;
        logic        exp_valid;
        logic        exp_err;
        logic [19:0] exp_data;
        logic [5:0]  exp_point;
        logic        exp_sign;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   valid_cnt = 0;
    int   err_cnt = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    seg_led_capture_if bus();

    seg_led_capture #(.STABLE_CYC(16), .TIMEOUT_CYC(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.valid) valid_cnt++;
        if (bus.err)   err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] sel, input logic [7:0] led, input int n);
        bus.seg_sel = sel;
        bus.seg_led = led;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scan slots 5 down to 'last'; optional 5-cycle glitch on slot 5 after slot 3.
    task automatic scan_slots(input logic [47:0] pat, input logic glitch, input int last);
        for (int s = 5; s >= last; s--) begin
            drive(~(6'd1 << s), pat[s*8 +: 8], HOLD);
            if (glitch && s == 3)
                drive(6'b011111, 8'h88, 5);
        end
    endtask

    task automatic measure(output int first_valid, output int first_err, output int nvalid);
        first_valid = 0;
        first_err   = 0;
        nvalid      = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.valid) begin
                nvalid++;
                if (first_valid == 0) first_valid = n;
            end
            if (bus.err && first_err == 0) first_err = n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},  32'(bus.data),  32'd0);
        check({tag, "_point"}, 32'(bus.point), 32'd0);
        check({tag, "_sign"},  32'(bus.sign),  32'd0);
        check({tag, "_en"},    32'(bus.en),    32'd0);
        check({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check({tag, "_err"},   32'(bus.err),   32'd0);
    endtask

    initial begin
        int v0, e0, fv, fe, nv;
        logic [19:0] held;

        vecs[0] = '{pat:48'hF9A4B0999282, glitch:1'b0, exp_valid:1'b1, exp_err:1'b0,
                    exp_data:20'h1E240, exp_point:6'b000000, exp_sign:1'b0};
        vecs[1] = '{pat:48'hFFFFFFBF79A4, glitch:1'b0, exp_valid:1'b1, exp_err:1'b0,
                    exp_data:20'd12, exp_point:6'b000010, exp_sign:1'b1};
        vecs[2] = '{pat:48'hF9A4B0889282, glitch:1'b0, exp_valid:1'b0, exp_err:1'b1,
                    exp_data:20'd12, exp_point:6'b000010, exp_sign:1'b1};
        vecs[3] = '{pat:48'hBFBFF9A4B099, glitch:1'b0, exp_valid:1'b0, exp_err:1'b1,
                    exp_data:20'd12, exp_point:6'b000010, exp_sign:1'b1};
        vecs[4] = '{pat:48'h1080F8829240, glitch:1'b0, exp_valid:1'b1, exp_err:1'b0,
                    exp_data:20'd987650, exp_point:6'b100001, exp_sign:1'b0};
        vecs[5] = '{pat:48'h909090909090, glitch:1'b0, exp_valid:1'b1, exp_err:1'b0,
                    exp_data:20'hF423F, exp_point:6'b000000, exp_sign:1'b0};
        vecs[6] = '{pat:48'hC0C0C0C0C0C0, glitch:1'b0, exp_valid:1'b1, exp_err:1'b0,
                    exp_data:20'd0, exp_point:6'b000000, exp_sign:1'b0};
        vecs[7] = '{pat:48'hB0999282F880, glitch:1'b1, exp_valid:1'b1, exp_err:1'b0,
                    exp_data:20'h5464E, exp_point:6'b000000, exp_sign:1'b0};
        vecs[8] = '{pat:48'hF9F9F9F9F9C1, glitch:1'b0, exp_valid:1'b0, exp_err:1'b1,
                    exp_data:20'h5464E, exp_point:6'b000000, exp_sign:1'b0};
        vecs[9] = '{pat:48'hFFFFFFFFFFBF, glitch:1'b0, exp_valid:1'b1, exp_err:1'b0,
                    exp_data:20'd0, exp_point:6'b000000, exp_sign:1'b1};

        rst         = 1'b1;
        bus.seg_sel = 6'h3F;
        bus.seg_led = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            scan_slots(vecs[i].pat, vecs[i].glitch, 0);
            drive(6'h3F, 8'hFF, 40);
            check($sformatf("v%0d_valid", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_err", i),   32'(err_cnt - e0),   32'(vecs[i].exp_err));
            check($sformatf("v%0d_data", i),  32'(bus.data),       32'(vecs[i].exp_data));
            check($sformatf("v%0d_point", i), 32'(bus.point),      32'(vecs[i].exp_point));
            check($sformatf("v%0d_sign", i),  32'(bus.sign),       32'(vecs[i].exp_sign));
            check($sformatf("v%0d_en", i),    32'(bus.en),         32'd1);
        end

        // Latency: last slot latches 18 edges after it hits the pins, valid 8 later.
        scan_slots(48'h8292_99B0_A4F9, 1'b0, 1);
        bus.seg_sel = 6'b111110;
        bus.seg_led = 8'hF9;
        measure(fv, fe, nv);
        check("lat_valid_cycle", 32'(fv), 32'd26);
        check("lat_valid_width", 32'(nv), 32'd1);
        check("lat_no_err",      32'(fe), 32'd0);
        check("lat_data",        32'(bus.data), 32'd654321);

        // Error latency: rejected frame pulses err 2 cycles after completion.
        scan_slots(48'hF9A4B0999288, 1'b0, 1);
        bus.seg_sel = 6'b111110;
        bus.seg_led = 8'h88;
        measure(fv, fe, nv);
        check("errlat_cycle",    32'(fe), 32'd20);
        check("errlat_no_valid", 32'(nv), 32'd0);
        check("errlat_hold",     32'(bus.data), 32'd654321);

        held = bus.data;
        drive(6'h3F, 8'hFF, 50);
        check("tmo_en_early", 32'(bus.en), 32'd1);
        drive(6'h3F, 8'hFF, 60);
        check("tmo_en_late",  32'(bus.en), 32'(EXP_EN_TMO));
        check("tmo_data_hold", 32'(bus.data), 32'd654321);
        check("tmo_data_same", 32'(bus.data), 32'(held));

        // Reset while the conversion is running discards the frame.
        scan_slots(48'hF9A4B0999282, 1'b0, 1);
        v0 = valid_cnt;
        e0 = err_cnt;
        bus.seg_sel = 6'b111110;
        bus.seg_led = 8'h82;
        repeat (22) @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.seg_sel = 6'h3F;
        bus.seg_led = 8'hFF;
        #1;
        check_outputs_zero("rstconv");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        measure(fv, fe, nv);
        check("rstconv_no_valid", 32'(nv), 32'd0);
        check("rstconv_no_err",   32'(fe), 32'd0);
        check("rstconv_cnt",      32'((valid_cnt - v0) + (err_cnt - e0)), 32'd0);

        v0 = valid_cnt;
        scan_slots(48'hF9A4B0999282, 1'b0, 0);
        drive(6'h3F, 8'hFF, 40);
        check("post_rst_valid", 32'(valid_cnt - v0), 32'd1);
        check("post_rst_data",  32'(bus.data), 32'h1E240);
        check("post_rst_en",    32'(bus.en),   32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
